// File: rtl/ps2_key_tx.sv
// PS/2 keyboard transmitter: turns MiSTer ps2_key toggle events into set-2
// scancode byte sequences, queues them and serializes device-to-host frames.
module ps2_key_tx #(
   parameter int unsigned HALF_PERIOD = 1145,
   parameter int unsigned GAP_CYCLES  = 2290,
   parameter int unsigned FIFO_DEPTH  = 8
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic [10:0] ps2_key,
   output logic        ps2_clk,
   output logic        ps2_data,
   output logic        busy,
   output logic        overflow
);

   localparam int unsigned AW      = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_MAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] HP_LAST  = CW'(HALF_PERIOD - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
   localparam logic [AW:0]   DEPTH_W  = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HI,
      S_LO,
      S_GAP
   } ser_state_t;

   // ---------------- event detection and composer ----------------
   logic        primed;
   logic        last_tog;
   logic        comp_busy;
   logic [1:0]  comp_len;
   logic [1:0]  comp_idx;
   logic [7:0]  comp_b0, comp_b1, comp_b2;
   logic [7:0]  wr_byte;

   logic        ev_pending;
   logic        ev_fits;
   logic [1:0]  ev_len;
   logic [7:0]  ev_b0, ev_b1, ev_b2;

   // ---------------- FIFO ----------------
   logic [7:0]  fifo_mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic [AW:0] used, free;
   logic        fifo_empty, fifo_full;
   logic [7:0]  rd_byte;

   // ---------------- serializer ----------------
   ser_state_t  state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [3:0]  idx, idx_nx;
   logic [9:0]  frame, frame_nx;
   logic        clk_nx, data_nx;
   logic        pop;

   always_comb begin
      used       = wr_ptr - rd_ptr;
      free       = DEPTH_W - used;
      fifo_empty = (wr_ptr == rd_ptr);
      fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      rd_byte    = fifo_mem[rd_ptr[AW-1:0]];
   end

   // Sequence is packed front-first into ev_b0..ev_b2 so the composer just counts.
   always_comb begin
      ev_pending = primed && !comp_busy && (ps2_key[10] != last_tog);
      ev_len     = 2'd1 + {1'b0, ps2_key[8]} + {1'b0, ~ps2_key[9]};
      ev_b0      = ps2_key[7:0];
      ev_b1      = '0;
      ev_b2      = '0;
      case ({ps2_key[8], ps2_key[9]})
         2'b01: ev_b0 = ps2_key[7:0];
         2'b11: begin
            ev_b0 = 8'hE0;
            ev_b1 = ps2_key[7:0];
         end
         2'b00: begin
            ev_b0 = 8'hF0;
            ev_b1 = ps2_key[7:0];
         end
         default: begin
            ev_b0 = 8'hE0;
            ev_b1 = 8'hF0;
            ev_b2 = ps2_key[7:0];
         end
      endcase
      ev_fits = !fifo_full && (free >= (AW+1)'(ev_len));
   end

   always_comb begin
      case (comp_idx)
         2'd0:    wr_byte = comp_b0;
         2'd1:    wr_byte = comp_b1;
         default: wr_byte = comp_b2;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         primed    <= 1'b0;
         last_tog  <= 1'b0;
         comp_busy <= 1'b0;
         comp_len  <= '0;
         comp_idx  <= '0;
         comp_b0   <= '0;
         comp_b1   <= '0;
         comp_b2   <= '0;
         overflow  <= 1'b0;
      end else begin
         overflow <= 1'b0;
         if (!primed) begin
            primed   <= 1'b1;
            last_tog <= ps2_key[10];
         end else if (ev_pending) begin
            last_tog <= ps2_key[10];
            if (ev_fits) begin
               comp_busy <= 1'b1;
               comp_len  <= ev_len;
               comp_idx  <= '0;
               comp_b0   <= ev_b0;
               comp_b1   <= ev_b1;
               comp_b2   <= ev_b2;
            end else begin
               overflow <= 1'b1;
            end
         end else if (comp_busy) begin
            comp_idx <= comp_idx + 2'd1;
            if (comp_idx == comp_len - 2'd1)
               comp_busy <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (comp_busy)
         fifo_mem[wr_ptr[AW-1:0]] <= wr_byte;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (comp_busy)
            wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)
            rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // frame holds the bits still to be sent after the one currently on ps2_data.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      idx_nx   = idx;
      frame_nx = frame;
      clk_nx   = ps2_clk;
      data_nx  = ps2_data;
      pop      = 1'b0;
      case (state)
         S_IDLE: begin
            clk_nx  = 1'b1;
            data_nx = 1'b1;
            if (!fifo_empty) begin
               pop      = 1'b1;
               frame_nx = {1'b1, ~^rd_byte, rd_byte};
               data_nx  = 1'b0;
               idx_nx   = '0;
               cnt_nx   = '0;
               state_nx = S_HI;
            end
         end
         S_HI: begin
            if (cnt == HP_LAST) begin
               cnt_nx   = '0;
               clk_nx   = 1'b0;
               state_nx = S_LO;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         S_LO: begin
            if (cnt == HP_LAST) begin
               cnt_nx = '0;
               clk_nx = 1'b1;
               if (idx == 4'd10) begin
                  data_nx  = 1'b1;
                  state_nx = S_GAP;
               end else begin
                  idx_nx   = idx + 4'd1;
                  data_nx  = frame[0];
                  frame_nx = {1'b1, frame[9:1]};
                  state_nx = S_HI;
               end
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         S_GAP: begin
            if (cnt == GAP_LAST) begin
               cnt_nx   = '0;
               state_nx = S_IDLE;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         idx      <= '0;
         frame    <= '0;
         ps2_clk  <= 1'b1;
         ps2_data <= 1'b1;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         idx      <= idx_nx;
         frame    <= frame_nx;
         ps2_clk  <= clk_nx;
         ps2_data <= data_nx;
      end
   end

   always_comb begin
      busy = !fifo_empty || comp_busy || (state != S_IDLE);
   end

endmodule

// File: tb/tb_ps2_key_tx.sv
// Scoreboard bench for ps2_key_tx: stimulus predicts byte sequences and drops,
// a line monitor decodes PS/2 frames and checks them against the queue.
module tb_ps2_key_tx;

   localparam int unsigned HP    = 4;
   localparam int unsigned GAP   = 8;
   localparam int unsigned DEPTH = 4;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic [10:0] ps2_key = 11'h400;
   logic        ps2_clk, ps2_data, busy, overflow;

   ps2_key_tx #(
      .HALF_PERIOD(HP),
      .GAP_CYCLES (GAP),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .ps2_key (ps2_key),
      .ps2_clk (ps2_clk),
      .ps2_data(ps2_data),
      .busy    (busy),
      .overflow(overflow)
   );

   always #5 clk_sys = ~clk_sys;

   int cyc = 0;
   always @(posedge clk_sys) cyc++;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
      end
   endtask

   // ---------------- scoreboard state ----------------
   logic [7:0] exp_q[$];
   int         enq_total   = 0;
   int         ovf_exp     = 0;
   bit         model_tog   = 1'b1;

   // ---------------- line monitor ----------------
   logic [10:0] mon_bits = '0;
   logic [10:0] last_bits = '0;
   int          nbits = 0;
   bit          in_frame = 1'b0;
   int          start_cyc = 0;
   int          end_cyc = 0;
   int          started_cnt = 0;
   int          ovf_seen = 0;
   int          unstable = 0;
   logic        prev_clk = 1'b1;
   logic        prev_data = 1'b1;
   logic [7:0]  got_byte[$];
   logic        got_par[$];
   int          got_start[$];

   task automatic finish_frame();
      logic [7:0] d;
      logic [7:0] e;
      d = mon_bits[8:1];
      check("frame_len", cyc - start_cyc, 22 * HP);
      check("data_stable_in_lo", unstable, 0);
      check("start_bit", int'(mon_bits[0]), 0);
      check("stop_bit", int'(mon_bits[10]), 1);
      check("odd_parity", $countones(mon_bits[9:1]) % 2, 1);
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_frame: got byte 0x%0h, expected no frame", d);
      end else begin
         e = exp_q.pop_front();
         check("frame_byte", d, e);
      end
      got_byte.push_back(d);
      got_par.push_back(mon_bits[9]);
      got_start.push_back(start_cyc);
      last_bits = mon_bits;
      end_cyc   = cyc;
      in_frame  = 1'b0;
   endtask

   always @(negedge clk_sys) begin
      if (!reset_n) begin
         in_frame  = 1'b0;
         nbits     = 0;
         prev_clk  = 1'b1;
         prev_data = 1'b1;
      end else begin
         if (overflow) ovf_seen++;
         if (!in_frame && prev_data && !ps2_data && ps2_clk) begin
            in_frame  = 1'b1;
            nbits     = 0;
            unstable  = 0;
            start_cyc = cyc;
            started_cnt++;
         end
         if (in_frame) begin
            if (prev_clk && !ps2_clk && nbits < 11) begin
               mon_bits[nbits] = ps2_data;
               nbits++;
            end else if (!prev_clk && !ps2_clk && ps2_data != prev_data) begin
               unstable++;
            end
            if (!prev_clk && ps2_clk && nbits == 11) finish_frame();
         end
         prev_clk  = ps2_clk;
         prev_data = ps2_data;
      end
   end

   // ---------------- stimulus / reference model ----------------
   task automatic issue(input bit pressed, input bit ext, input logic [7:0] code);
      logic [7:0] seq[$];
      int occ, free;
      if (ext) seq.push_back(8'hE0);
      if (!pressed) seq.push_back(8'hF0);
      seq.push_back(code);
      occ  = enq_total - started_cnt;
      free = int'(DEPTH) - occ;
      if (free >= seq.size()) begin
         foreach (seq[i]) exp_q.push_back(seq[i]);
         enq_total += seq.size();
      end else begin
         ovf_exp++;
      end
      model_tog = ~model_tog;
      ps2_key   = {model_tog, pressed, ext, code};
   endtask

   // Occupancy is only predictable when no pop can land before evaluation:
   // either everything is idle, or a frame is mid-way (clock low).
   task automatic event_safe(input bit pressed, input bit ext, input logic [7:0] code);
      int n;
      n = 0;
      @(negedge clk_sys);
      while (busy && ps2_clk && n < 400) begin
         @(negedge clk_sys);
         n++;
      end
      if (n >= 400) check("safe_window_timeout", n, 0);
      issue(pressed, ext, code);
      repeat (5) @(negedge clk_sys);
   endtask

   task automatic wait_idle(input int max_cyc, input string name);
      int n;
      n = 0;
      repeat (2) @(negedge clk_sys);
      while (busy && n < max_cyc) begin
         @(negedge clk_sys);
         n++;
      end
      check({name, "_idle"}, int'(busy), 0);
   endtask

   task automatic settle(input string name);
      check({name, "_overflow_count"}, ovf_seen, ovf_exp);
      check({name, "_queue_drained"}, exp_q.size(), 0);
   endtask

   task automatic clear_log();
      got_byte.delete();
      got_par.delete();
      got_start.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      int ovf_before;
      int n;
      int bad_clk;
      int bad_busy;

      // reset state
      repeat (3) @(negedge clk_sys);
      check("rst_ps2_clk", int'(ps2_clk), 1);
      check("rst_ps2_data", int'(ps2_data), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_overflow", int'(overflow), 0);
      reset_n = 1'b1;
      repeat (20) @(negedge clk_sys);
      check("no_spurious_busy", int'(busy), 0);
      check("no_spurious_frame", started_cnt, 0);
      check("no_spurious_ovf", ovf_seen, 0);

      // single press 1C
      clear_log();
      event_safe(1'b1, 1'b0, 8'h1C);
      wait_idle(400, "press1c");
      check("press1c_bits", int'(last_bits), int'(11'b100_0011_1000));
      check("press1c_frames", got_byte.size(), 1);
      check("press1c_gap_to_idle", cyc - end_cyc, GAP);
      settle("press1c");

      // extended release 75
      clear_log();
      event_safe(1'b0, 1'b1, 8'h75);
      wait_idle(800, "rel75");
      check("rel75_frames", got_byte.size(), 3);
      if (got_byte.size() == 3) begin
         check("rel75_par0", int'(got_par[0]), 0);
         check("rel75_par1", int'(got_par[1]), 1);
         check("rel75_par2", int'(got_par[2]), 0);
         check("rel75_spacing01", got_start[1] - got_start[0], 22 * HP + GAP + 1);
         check("rel75_spacing12", got_start[2] - got_start[1], 22 * HP + GAP + 1);
      end
      settle("rel75");

      // back-to-back events before the first frame starts
      clear_log();
      @(negedge clk_sys);
      issue(1'b1, 1'b0, 8'h12);
      @(negedge clk_sys);
      issue(1'b0, 1'b1, 8'h14);
      wait_idle(1000, "b2b");
      check("b2b_frames", got_byte.size(), 4);
      settle("b2b");

      // overflow with one free entry
      clear_log();
      event_safe(1'b1, 1'b0, 8'h12);
      event_safe(1'b0, 1'b1, 8'h14);
      ovf_before = ovf_seen;
      event_safe(1'b0, 1'b0, 8'h1C);
      check("ovf_single_pulse", ovf_seen - ovf_before, 1);
      event_safe(1'b1, 1'b0, 8'h22);
      wait_idle(1200, "ovf");
      check("ovf_frames", got_byte.size(), 5);
      settle("ovf");

      // reset mid-frame at bit 5
      event_safe(1'b1, 1'b0, 8'h4A);
      n = 0;
      while (!(in_frame && nbits == 5 && !ps2_clk) && n < 300) begin
         @(negedge clk_sys);
         n++;
      end
      check("abort_reach_bit5", int'(n < 300), 1);
      #2 reset_n = 1'b0;
      #1;
      check("abort_ps2_clk", int'(ps2_clk), 1);
      check("abort_ps2_data", int'(ps2_data), 1);
      check("abort_busy", int'(busy), 0);
      exp_q.delete();
      repeat (3) @(negedge clk_sys);
      reset_n   = 1'b1;
      enq_total = started_cnt;
      bad_clk   = 0;
      bad_busy  = 0;
      repeat (200) begin
         @(negedge clk_sys);
         if (!ps2_clk) bad_clk++;
         if (busy) bad_busy++;
      end
      check("after_abort_clk_idle", bad_clk, 0);
      check("after_abort_busy_idle", bad_busy, 0);
      clear_log();
      event_safe(1'b1, 1'b0, 8'h29);
      wait_idle(400, "after_abort");
      check("after_abort_frames", got_byte.size(), 1);
      settle("after_abort");

      // randomized events
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 60)) @(negedge clk_sys);
         event_safe(1'($urandom), 1'($urandom), 8'($urandom));
      end
      wait_idle(3000, "random");
      settle("random");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
